// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking-lot occupancy/statistics datapath.
// Holds the rush-hour FSM state encoding and a generic saturating increment.
package parking_pkg;

  typedef enum logic [1:0] {
    RUSH_IDLE   = 2'd0,
    RUSH_ACTIVE = 2'd1,
    RUSH_DONE   = 2'd2
  } rush_state_t;

  // Width of the generic saturating helper; callers cast in and out of it.
  localparam int SAT_W = 32;

  // Increment count by one, holding at max once reached.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] count,
                                               input logic [SAT_W-1:0] max);
    if (count >= max) begin
      return max;
    end
    return count + SAT_W'(1);
  endfunction

endpackage

// File: rtl/parking_hour_hist.sv
// Per-hour entry histogram: a flop array of saturating counters indexed by hour,
// cleared in a single cycle by reset, with a registered one-cycle-latency read port.
// A read of the bin being incremented returns the pre-increment value.
module parking_hour_hist
  import parking_pkg::*;
#(
  parameter int HOUR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic [HOUR_W-1:0] wr_hour_i,
  input  logic [HOUR_W-1:0] rd_hour_i,
  output logic [CNT_W-1:0]  rd_count_o
);

  localparam int NUM_HOURS = 2 ** HOUR_W;
  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] bins_q [NUM_HOURS];
  logic [CNT_W-1:0] bin_inc_d;
  logic [CNT_W-1:0] rd_count_q;

  // Saturated next value of the bin currently addressed for writing.
  always_comb begin
    bin_inc_d = CNT_W'(sat_inc(SAT_W'(bins_q[wr_hour_i]), CNT_MAX));
  end

  // Bin update on accepted entry plus registered read of the addressed bin.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_HOURS; i++) begin
        bins_q[i] <= '0;
      end
      rd_count_q <= '0;
    end else begin
      if (inc_i) begin
        bins_q[wr_hour_i] <= bin_inc_d;
      end
      rd_count_q <= bins_q[rd_hour_i];
    end
  end

  assign rd_count_o = rd_count_q;

endmodule

// File: rtl/parking_occupancy_stats.sv
// Parking-lot occupancy and statistics datapath.
// Tracks cars against CAPACITY, counts accepted entries (saturating), logs a
// per-hour entry histogram and records rush-hour start/end hours.
// Optional feature: define PARKING_REJECT_CNT_EN to add a saturating counter of
// rejected entry requests on output 'rejected'.
module parking_occupancy_stats
  import parking_pkg::*;
#(
  parameter int CAPACITY = 3,
  parameter int HOUR_W   = 3,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enter,
  input  logic                          exit,
  input  logic [HOUR_W-1:0]             hour,
  input  logic [HOUR_W-1:0]             rd_hour,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic                          full,
  output logic                          empty,
  output logic [CNT_W-1:0]              total_entries,
  output logic [CNT_W-1:0]              rd_count,
  output logic [HOUR_W-1:0]             rush_start,
  output logic [HOUR_W-1:0]             rush_end,
  output logic                          rush_seen,
  output logic                          rush_over
`ifdef PARKING_REJECT_CNT_EN
  ,
  output logic [CNT_W-1:0]              rejected
`endif
);

  localparam int OCC_W = $clog2(CAPACITY + 1);
  localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);
  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'((64'd1 << CNT_W) - 64'd1);

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              exit_ok, enter_ok;
  rush_state_t       state_q;
  logic [HOUR_W-1:0] rush_start_q, rush_end_q;
  logic              rush_seen_q, rush_over_q;

  // Acceptance is decided on registered occupancy; an exit frees a slot
  // in the same cycle, so a full lot still accepts an entry paired with an exit.
  always_comb begin
    exit_ok  = exit && (occ_q != '0);
    enter_ok = enter && ((occ_q < CAP_V) || exit_ok);
    occ_d    = occ_q;
    if (enter_ok && !exit_ok) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!enter_ok && exit_ok) begin
      occ_d = occ_q - OCC_W'(1);
    end
    total_d = total_q;
    if (enter_ok) begin
      total_d = CNT_W'(sat_inc(SAT_W'(total_q), CNT_MAX));
    end
  end

  // Occupancy and total-entry registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= '0;
      total_q <= '0;
    end else begin
      occ_q   <= occ_d;
      total_q <= total_d;
    end
  end

  // Rush FSM: watches registered occupancy, so it reacts one cycle after the
  // lot fills or empties; DONE is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUSH_IDLE;
      rush_start_q <= '0;
      rush_end_q   <= '0;
      rush_seen_q  <= 1'b0;
      rush_over_q  <= 1'b0;
    end else begin
      case (state_q)
        RUSH_IDLE: begin
          if (occ_q == CAP_V) begin
            state_q      <= RUSH_ACTIVE;
            rush_start_q <= hour;
            rush_seen_q  <= 1'b1;
          end
        end
        RUSH_ACTIVE: begin
          if (occ_q == '0) begin
            state_q     <= RUSH_DONE;
            rush_end_q  <= hour;
            rush_over_q <= 1'b1;
          end
        end
        RUSH_DONE: begin
          state_q <= RUSH_DONE;
        end
        default: begin
          state_q <= RUSH_IDLE;
        end
      endcase
    end
  end

`ifdef PARKING_REJECT_CNT_EN
  logic [CNT_W-1:0] rejected_q;

  // Saturating count of entry requests turned away.
  always_ff @(posedge clk) begin
    if (reset) begin
      rejected_q <= '0;
    end else if (enter && !enter_ok) begin
      rejected_q <= CNT_W'(sat_inc(SAT_W'(rejected_q), CNT_MAX));
    end
  end

  assign rejected = rejected_q;
`endif

  parking_hour_hist #(
    .HOUR_W (HOUR_W),
    .CNT_W  (CNT_W)
  ) u_hist (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (enter_ok),
    .wr_hour_i  (hour),
    .rd_hour_i  (rd_hour),
    .rd_count_o (rd_count)
  );

  assign occupancy     = occ_q;
  assign full          = (occ_q == CAP_V);
  assign empty         = (occ_q == '0);
  assign total_entries = total_q;
  assign rush_start    = rush_start_q;
  assign rush_end      = rush_end_q;
  assign rush_seen     = rush_seen_q;
  assign rush_over     = rush_over_q;

endmodule

// File: doc/parking_occupancy_stats.md
Name: parking_occupancy_stats

Overview:
- Parametrised occupancy and statistics datapath for the parking-lot controller.
- Tracks cars in the lot against a configurable capacity and counts total accepted entries.
- Keeps a per-hour entry histogram and records rush-hour start/end via a three-state FSM.
- Sits between the entry/exit sensor FSM and the HEX display/report logic.

Parameters:
- CAPACITY, 3, maximum cars in lot (>=1)
- HOUR_W, 3, width of hour index; NUM_HOURS = 2**HOUR_W
- CNT_W, 8, width of total-entry and histogram counters (saturating)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- enter  in  1  one-cycle pulse, car requests entry
- exit  in  1  one-cycle pulse, car leaves
- hour  in  HOUR_W  current hour index from hour counter
- rd_hour  in  HOUR_W  histogram read address
- occupancy  out  $clog2(CAPACITY+1)  cars currently in lot
- full  out  1  occupancy == CAPACITY (combinational from register)
- empty  out  1  occupancy == 0
- total_entries  out  CNT_W  accepted entries since reset, saturating
- rd_count  out  CNT_W  entries logged in hour rd_hour, registered, 1-cycle latency
- rush_start  out  HOUR_W  hour rush began
- rush_end  out  HOUR_W  hour rush ended
- rush_seen  out  1  rush has started
- rush_over  out  1  rush has ended

Behaviour:
- Reset (already decided): reset reset, synchronous, active-high; clock clk.
- Reset values: occupancy 0, total_entries 0, all histogram bins 0, rd_count 0, rush_start 0, rush_end 0, rush_seen 0, rush_over 0, FSM IDLE.
- Histogram clear on reset takes one cycle (flop array, not RAM).
- Acceptance, evaluated on registered occupancy:
  - exit_ok = exit && occupancy>0
  - enter_ok = enter && (occupancy<CAPACITY || exit_ok)
- occupancy next = occupancy + enter_ok - exit_ok:
  - both pulses, 0<occ<CAP: unchanged.
  - Both pulses when full: net 0, entry still counted.
  - Both pulses when empty: +1, exit ignored.
  - Exit when empty: ignored.
  - Enter when full without exit: rejected, no count.
- total_entries += enter_ok; holds at 2**CNT_W-1.
- Histogram bin[hour] += enter_ok; saturates independently per bin. Hour wrap from NUM_HOURS-1 to 0 just re-addresses bins; it does not clear them.
- rd_count <= bin[rd_hour] each cycle. Read of the same bin being written returns the pre-increment value.
- Rush FSM (state in package), driven by registered occupancy, so one cycle after the occupancy change:
  - IDLE -> RUSH when occupancy==CAPACITY; rush_start<=hour, rush_seen<=1.
  - RUSH -> DONE when occupancy==0; rush_end<=hour, rush_over<=1.
  - DONE sticky until reset; later fills do not re-trigger.
- Reset mid-rush returns to IDLE with all outputs cleared next edge.
- CAPACITY=1: IDLE->RUSH on first entry.

Optional Feature:
- Macro PARKING_REJECT_CNT_EN.
- Defined: adds output rejected (CNT_W), incremented saturating on enter && !enter_ok, reset 0.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
- Package parking_pkg:
  - rush_state_t enum {RUSH_IDLE, RUSH_ACTIVE, RUSH_DONE}
  - function sat_inc(count, max) for saturating increment
- One sub-module parking_hour_hist (params HOUR_W, CNT_W): bin array, saturating increment on inc strobe at wr_hour, registered read port.
- Occupancy counter and FSM stay in the top.

Test Plan (CAPACITY=3, HOUR_W=3, CNT_W=8):
- Reset, then 4 enter pulses at hour 0 -> occupancy 0,1,2,3,3; full=1; total_entries=3; 4th rejected (rejected=1 with macro).
- Fill to 3 at hour 2 -> rush_seen=1, rush_start=2 one cycle after occupancy hits 3. Drain to 0 at hour 5 -> rush_over=1, rush_end=5. Refill at hour 6 -> rush_start stays 2.
- Simultaneous enter+exit at occ 3, 1, 0 -> occupancy 3, 1, 1; total_entries +1 each time.
- Entries: 2 at hour 1, 1 at hour 7, then hour wraps to 0 and 1 more at hour 1 -> rd_hour=1 gives rd_count=3 next cycle; rd_hour=7 gives 1.
- 300 enter/exit pairs at hour 4 -> total_entries and bin[4] saturate at 255; no wrap to 0.
- Assert reset while in RUSH_ACTIVE with occupancy 2 -> next cycle all outputs 0, FSM IDLE, rd_count of every bin 0.
